// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module : serial_subtractor_pkg
// Brief  : State encoding and helper function shared by the serial subtractor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// Module : full_subtractor
// Brief  : Single-bit full subtractor cell, x - y - bin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial unsigned subtractor, diff = a - b, LSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sr_q,   a_sr_d;
   logic [WIDTH-1:0] b_sr_q,   b_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             bflop_q,  bflop_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             borrow_q, borrow_d;

   logic             fs_d;
   logic             fs_bo;
   logic [WIDTH-1:0] res_next;

   full_subtractor u_fs (
      .x    (a_sr_q[0]),
      .y    (b_sr_q[0]),
      .bin  (bflop_q),
      .d    (fs_d),
      .bout (fs_bo)
   );

   // Result fills from the MSB so after WIDTH shifts bit 0 sits at the LSB.
   assign res_next = {fs_d, res_sr_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      cnt_d    = cnt_q;
      bflop_d  = bflop_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_SHIFT;
               a_sr_d   = a;
               b_sr_d   = b;
               res_sr_d = '0;
               cnt_d    = '0;
               bflop_d  = 1'b0;
            end
         end
         S_SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_next;
            bflop_d  = fs_bo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == C_LAST) begin
               state_d  = S_DONE;
               diff_d   = res_next;
               borrow_d = fs_bo;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         cnt_q    <= '0;
         bflop_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         cnt_q    <= cnt_d;
         bflop_q  <= bflop_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

`default_nettype wire
